// File: rtl/store_responder_pkg.sv
// -----------------------------------------------------------------------------
// store_responder_pkg
// Shared types for the store responder: register-width values, word
// addresses, the posted-store FIFO entry and the issue FSM state encoding.
// -----------------------------------------------------------------------------
package store_responder_pkg;

    typedef logic [31:0] regval_t;
    typedef logic [29:0] mem_word_t;

    // One posted store: word address plus the data to write there.
    typedef struct packed {
        mem_word_t word;
        regval_t   value;
    } store_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } issue_state_t;

endpackage

// File: rtl/store_responder_if.sv
// -----------------------------------------------------------------------------
// store_responder_if
// Bundles the write-stage store handshake and the data-memory bus.
//   slave  : the responder (drives data_valid, is_empty, pulses, mem_* outputs)
//   master : the surrounding pipeline and memory (drives the store request
//            and mem_waitrequest)
// -----------------------------------------------------------------------------
interface store_responder_if;
    import store_responder_pkg::*;

    logic      address_enable;
    regval_t   address;
    regval_t   data;
    logic      data_valid;
    logic      is_empty;
    logic      misaligned;
    logic      timeout;
    mem_word_t mem_address;
    regval_t   mem_writedata;
    logic      mem_write;
    logic      mem_waitrequest;

    modport slave (
        input  address_enable, address, data, mem_waitrequest,
        output data_valid, is_empty, misaligned, timeout,
               mem_address, mem_writedata, mem_write
    );

    modport master (
        output address_enable, address, data, mem_waitrequest,
        input  data_valid, is_empty, misaligned, timeout,
               mem_address, mem_writedata, mem_write
    );
endinterface

// File: rtl/store_fifo.sv
// -----------------------------------------------------------------------------
// store_fifo
// Posted-store FIFO, DEPTH entries (power of two). Pointers carry one extra
// wrap bit so full and empty are distinguished by count = wr_ptr - rd_ptr.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   push, push_entry : write one entry (caller never pushes when full)
//   pop            : drop the head (caller never pops when empty)
//   head           : current oldest entry
//   count          : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module store_fifo
    import store_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  store_entry_t             push_entry,
    input  logic                     pop,
    output store_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    store_entry_t  entries [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // NOTE: the entry array is deliberately not reset; the pointers alone
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign head  = entries[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/store_responder.sv
// -----------------------------------------------------------------------------
// store_responder
// Memory-side responder for the write stage's stores. Accepted stores are
// posted into a FIFO and drained in order onto a word-addressed memory bus
// with wait-request flow control; a stalled transfer is abandoned after
// WAIT_LIMIT consecutive stalled edges.
//
// Configuration macro: STORE_RESPONDER_BUFFER_EN
//   defined   : FIFO + IDLE/BUSY issue FSM with registered bus outputs
//   undefined : bus driven combinationally from the store request
//
// Ports:
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : address_enable/address/data -> data_valid, is_empty,
//                    misaligned and timeout pulses, mem_address/
//                    mem_writedata/mem_write with mem_waitrequest
// Parameters: DEPTH (FIFO entries, power of two >= 2), WAIT_LIMIT (>= 1)
// -----------------------------------------------------------------------------
module store_responder
    import store_responder_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WAIT_LIMIT = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    store_responder_if.slave bus
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("store_responder: DEPTH must be a power of two >= 2");
    end
    if (WAIT_LIMIT < 1) begin : g_bad_limit
        $error("store_responder: WAIT_LIMIT must be >= 1");
    end

    // The counter only has to reach WAIT_LIMIT-1: the edge that would make it
    // WAIT_LIMIT is the abandoning edge itself.
    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam logic [CW-1:0] LAST_STALL = CW'(WAIT_LIMIT - 1);
    localparam logic [CW-1:0] STALL_ONE  = CW'(1);

    logic [CW-1:0] stall_cnt;
    logic          stalled;
    logic          timeout_hit;

    assign timeout_hit = stalled && (stall_cnt == LAST_STALL);

`ifdef STORE_RESPONDER_BUFFER_EN
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW:0]  count;
    store_entry_t head;
    store_entry_t push_entry;
    issue_state_t state;
    issue_state_t next_state;
    logic         push;
    logic         pop;
    logic         fifo_empty;
    logic         xfer_done;

    // Acceptance looks at the pre-pop count: a full FIFO never accepts,
    // even on an edge that also pops.
    assign bus.data_valid = bus.address_enable && (count != FULL_COUNT);
    assign push           = bus.address_enable && bus.data_valid;
    assign push_entry     = '{word: bus.address[31:2], value: bus.data};
    assign fifo_empty     = (count == '0);

    assign stalled   = (state == BUSY) && bus.mem_waitrequest;
    assign xfer_done = (state == BUSY) && (!bus.mem_waitrequest || timeout_hit);
    // Popping on completion keeps back-to-back transfers bubble-free.
    assign pop       = !fifo_empty && ((state == IDLE) || xfer_done);

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (!fifo_empty)              next_state = BUSY;
            BUSY: if (xfer_done && fifo_empty)  next_state = IDLE;
            default:                            next_state = IDLE;
        endcase
    end

    // Issue registers load only on a pop, so they hold steady during stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
        end else if (pop) begin
            bus.mem_address   <= head.word;
            bus.mem_writedata <= head.value;
        end
    end

    assign bus.mem_write = (state == BUSY);
    assign bus.is_empty  = fifo_empty && (state == IDLE);
`else
    // Unbuffered: the store request is the bus transfer; the pipeline is
    // released on completion or when the transfer is abandoned.
    assign stalled           = bus.address_enable && bus.mem_waitrequest;
    assign bus.mem_write     = bus.address_enable;
    assign bus.mem_address   = bus.address[31:2];
    assign bus.mem_writedata = bus.data;
    assign bus.data_valid    = bus.address_enable &&
                               (!bus.mem_waitrequest || timeout_hit);
    assign bus.is_empty      = !bus.address_enable;
`endif

    // Counts consecutive stalled edges; anything else (completion, abandon,
    // idle) starts the next transfer from zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                    stall_cnt <= '0;
        else if (stalled && !timeout_hit) stall_cnt <= stall_cnt + STALL_ONE;
        else                             stall_cnt <= '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.misaligned <= 1'b0;
            bus.timeout    <= 1'b0;
        end else begin
            bus.misaligned <= bus.address_enable && bus.data_valid &&
                              (bus.address[1:0] != 2'b00);
            bus.timeout    <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_store_responder.sv
// -----------------------------------------------------------------------------
// tb_store_responder
// Directed bench for store_responder (DEPTH = 4, WAIT_LIMIT = 8). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Covers the buffered build when STORE_RESPONDER_BUFFER_EN is
// defined and the unbuffered build otherwise.
// -----------------------------------------------------------------------------
module tb_store_responder;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    store_responder_if bus();

    store_responder #(.DEPTH(4), .WAIT_LIMIT(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic drive(input logic ae, input logic [31:0] addr, input logic [31:0] dat);
        bus.address_enable = ae;
        bus.address        = addr;
        bus.data           = dat;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        bus.mem_waitrequest = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("rst_mem_write",  {31'b0, bus.mem_write},  32'd0);
        check("rst_is_empty",   {31'b0, bus.is_empty},   32'd1);
        check("rst_data_valid", {31'b0, bus.data_valid}, 32'd0);
        check("rst_timeout",    {31'b0, bus.timeout},    32'd0);
        check("rst_misaligned", {31'b0, bus.misaligned}, 32'd0);
        check("rst_mem_addr",   {2'b0, bus.mem_address}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cycle();

`ifdef STORE_RESPONDER_BUFFER_EN
        // Single aligned store: accepted same cycle, on the bus 2 edges later.
        drive(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        sample();
        check("single_dv",    {31'b0, bus.data_valid}, 32'd1);
        check("single_empty0", {31'b0, bus.is_empty},  32'd1);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("single_wr_e1",    {31'b0, bus.mem_write}, 32'd0);
        check("single_notempty", {31'b0, bus.is_empty},  32'd0);
        cycle();
        sample();
        check("single_wr_e2", {31'b0, bus.mem_write},   32'd1);
        check("single_addr",  {2'b0, bus.mem_address},  32'h401);
        check("single_data",  bus.mem_writedata,        32'hDEAD_BEEF);
        cycle();
        sample();
        check("single_wr_e3", {31'b0, bus.mem_write}, 32'd0);
        check("single_empty", {31'b0, bus.is_empty},  32'd1);
        cycle();

        // Misaligned store: pulse once, written at the truncated word address.
        drive(1'b1, 32'h0000_1006, 32'h1234_5678);
        sample();
        check("mis_dv", {31'b0, bus.data_valid}, 32'd1);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("mis_pulse", {31'b0, bus.misaligned}, 32'd1);
        cycle();
        sample();
        check("mis_pulse_end", {31'b0, bus.misaligned}, 32'd0);
        check("mis_wr",        {31'b0, bus.mem_write},  32'd1);
        check("mis_addr",      {2'b0, bus.mem_address}, 32'h401);
        check("mis_data",      bus.mem_writedata,       32'h1234_5678);
        cycle();

        // Full FIFO: 1 issued + 4 buffered under stall, 6th refused.
        bus.mem_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            sample();
            check("full_accept", {31'b0, bus.data_valid}, 32'd1);
            cycle();
        end
        drive(1'b1, 32'h114, 32'hC0DE_0005);
        bus.mem_waitrequest = 1'b0;
        sample();
        check("full_refuse",   {31'b0, bus.data_valid}, 32'd0);
        check("full_hold_adr", {2'b0, bus.mem_address}, 32'h40);
        check("full_hold_dat", bus.mem_writedata,       32'hC0DE_0000);
        cycle();
        sample();
        check("full_accept6", {31'b0, bus.data_valid}, 32'd1);
        check("full_addr1",   {2'b0, bus.mem_address}, 32'h41);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 2; k < 6; k++) begin
            sample();
            check("full_drain_wr",   {31'b0, bus.mem_write},  32'd1);
            check("full_drain_addr", {2'b0, bus.mem_address}, 32'h40 + 32'(k));
            check("full_drain_data", bus.mem_writedata,       32'hC0DE_0000 + 32'(k));
            cycle();
        end
        sample();
        check("full_done_wr",    {31'b0, bus.mem_write}, 32'd0);
        check("full_done_empty", {31'b0, bus.is_empty},  32'd1);
        cycle();

        // Timeout: two stores under a stuck wait-request, 8 stalls each.
        bus.mem_waitrequest = 1'b1;
        drive(1'b1, 32'h200, 32'hAAAA_0001);
        sample();
        check("to_dv0", {31'b0, bus.data_valid}, 32'd1);
        cycle();
        drive(1'b1, 32'h204, 32'hBBBB_0002);
        sample();
        check("to_dv1", {31'b0, bus.data_valid}, 32'd1);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        for (int c = 2; c <= 18; c++) begin
            sample();
            check($sformatf("to_pulse_c%0d", c), {31'b0, bus.timeout},
                  (c == 10 || c == 18) ? 32'd1 : 32'd0);
            check($sformatf("to_wr_c%0d", c), {31'b0, bus.mem_write},
                  (c < 18) ? 32'd1 : 32'd0);
            if (c < 18)
                check($sformatf("to_addr_c%0d", c), {2'b0, bus.mem_address},
                      (c < 10) ? 32'h80 : 32'h81);
            cycle();
        end
        sample();
        check("to_empty", {31'b0, bus.is_empty}, 32'd1);
        cycle();

        // Reset mid-burst: stores in flight are dropped, no replay.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 2) ? 32'h30A : 32'h300 + 32'(4 * i), 32'h5555_0000 + 32'(i));
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr",    {31'b0, bus.mem_write},  32'd0);
        check("mid_rst_empty", {31'b0, bus.is_empty},   32'd1);
        check("mid_rst_mis",   {31'b0, bus.misaligned}, 32'd0);
        check("mid_rst_to",    {31'b0, bus.timeout},    32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.mem_waitrequest = 1'b0;
        cycle();
        for (int k = 0; k < 4; k++) begin
            sample();
            check("no_replay_wr",    {31'b0, bus.mem_write}, 32'd0);
            check("no_replay_empty", {31'b0, bus.is_empty},  32'd1);
            cycle();
        end
`else
        // Single store passes straight through.
        drive(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        sample();
        check("single_dv",    {31'b0, bus.data_valid}, 32'd1);
        check("single_wr",    {31'b0, bus.mem_write},  32'd1);
        check("single_addr",  {2'b0, bus.mem_address}, 32'h401);
        check("single_data",  bus.mem_writedata,       32'hDEAD_BEEF);
        check("single_busy",  {31'b0, bus.is_empty},   32'd0);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("single_wr_off", {31'b0, bus.mem_write}, 32'd0);
        check("single_empty",  {31'b0, bus.is_empty},  32'd1);
        check("single_nomis",  {31'b0, bus.misaligned}, 32'd0);
        cycle();

        // Misaligned store.
        drive(1'b1, 32'h0000_1006, 32'h1234_5678);
        sample();
        check("mis_addr", {2'b0, bus.mem_address}, 32'h401);
        check("mis_data", bus.mem_writedata,       32'h1234_5678);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("mis_pulse", {31'b0, bus.misaligned}, 32'd1);
        cycle();
        sample();
        check("mis_pulse_end", {31'b0, bus.misaligned}, 32'd0);
        cycle();

        // Three stalled cycles, then release in the cycle wait-request falls.
        bus.mem_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h2000 + 32'(16 * k), 32'h7700_0000 + 32'(k));
            sample();
            check("stall_dv",   {31'b0, bus.data_valid}, 32'd0);
            check("stall_addr", {2'b0, bus.mem_address}, 32'h800 + 32'(4 * k));
            check("stall_data", bus.mem_writedata,       32'h7700_0000 + 32'(k));
            cycle();
        end
        drive(1'b1, 32'h2030, 32'h7700_0003);
        bus.mem_waitrequest = 1'b0;
        sample();
        check("stall_release", {31'b0, bus.data_valid}, 32'd1);
        check("stall_rel_adr", {2'b0, bus.mem_address}, 32'h80C);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("stall_no_to", {31'b0, bus.timeout}, 32'd0);
        cycle();

        // Timeout: 8th stalled edge abandons and releases the pipeline.
        bus.mem_waitrequest = 1'b1;
        drive(1'b1, 32'h3000, 32'h9999_0000);
        for (int k = 0; k < 8; k++) begin
            sample();
            check($sformatf("to_dv_c%0d", k), {31'b0, bus.data_valid},
                  (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("to_pulse_c%0d", k), {31'b0, bus.timeout}, 32'd0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0);
        bus.mem_waitrequest = 1'b0;
        sample();
        check("to_pulse", {31'b0, bus.timeout}, 32'd1);
        cycle();
        sample();
        check("to_pulse_end", {31'b0, bus.timeout},  32'd0);
        check("to_empty",     {31'b0, bus.is_empty}, 32'd1);
        cycle();

        // Reset mid-stall clears the stall counter.
        bus.mem_waitrequest = 1'b1;
        drive(1'b1, 32'h4000, 32'h4444_0000);
        for (int k = 0; k < 5; k++) cycle();
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        check("mid_rst_to",    {31'b0, bus.timeout},  32'd0);
        check("mid_rst_empty", {31'b0, bus.is_empty}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        cycle();
        drive(1'b1, 32'h4000, 32'h4444_0000);
        for (int k = 0; k < 8; k++) begin
            sample();
            check($sformatf("rst_cnt_dv_c%0d", k), {31'b0, bus.data_valid},
                  (k == 7) ? 32'd1 : 32'd0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0);
        bus.mem_waitrequest = 1'b0;
        cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
